// File: rtl/bmj_pkg.sv
// Shared definitions for the HPS-loader / CPU RAM arbiter slice.
package bmj_pkg;

    localparam int unsigned AW_DEFAULT         = 16;
    localparam logic [7:0]  LOAD_INDEX_DEFAULT = 8'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ADDR = 2'd1,
        CPU_DATA = 2'd2,
        LD_WRITE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ioctl_wr_buffer.sv
// One-entry capture buffer for loader writes; raises ioctl_wait while holding a write
// and flags writes that are out of range or arrive while it is full.
module ioctl_wr_buffer
    import bmj_pkg::*;
#(
    parameter int unsigned AW         = AW_DEFAULT,
    parameter logic [7:0]  LOAD_INDEX = LOAD_INDEX_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    input  logic          pop,
    output logic          full,
    output logic          ioctl_wait,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data,
    output logic          wr_err
);

    logic hit;
    logic in_range;
    logic capture;

    assign hit      = ioctl_download & ioctl_wr & (ioctl_index == LOAD_INDEX);
    assign in_range = (ioctl_addr >> AW) == '0;
    assign capture  = hit & in_range & ~full;
    assign wr_err   = hit & (full | ~in_range);

    // Wait tracks occupancy: it drops the cycle after the buffered write is issued.
    assign ioctl_wait = full;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (capture) begin
            full     <= 1'b1;
            buf_addr <= ioctl_addr[AW-1:0];
            buf_data <= ioctl_dout;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/ioctl_ram_arbiter.sv
// Shares a single-port synchronous RAM between CPU slot accesses and the HPS loader
// stream; the CPU always wins a collision and the buffered loader write follows.
module ioctl_ram_arbiter
    import bmj_pkg::*;
#(
    parameter int unsigned AW         = AW_DEFAULT,
    parameter logic [7:0]  LOAD_INDEX = LOAD_INDEX_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_slot,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic          load_busy,
    output logic [AW:0]   load_count,
    output logic          load_err
);

    arb_state_t    state_q, state_d;
    logic [AW-1:0] ram_addr_d;
    logic [7:0]    ram_din_d;
    logic          ram_we_d;
    logic          cpu_rd_q, cpu_rd_d;
    logic          cpu_req;
    logic          slot_err;
    logic          buf_pop;
    logic          buf_full;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          buf_err;
    logic          dl_q;
    logic          dl_rise;

    ioctl_wr_buffer #(
        .AW         (AW),
        .LOAD_INDEX (LOAD_INDEX)
    ) u_wr_buffer (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .pop            (buf_pop),
        .full           (buf_full),
        .ioctl_wait     (ioctl_wait),
        .buf_addr       (buf_addr),
        .buf_data       (buf_data),
        .wr_err         (buf_err)
    );

    assign cpu_req   = cpu_slot & cpu_cs;
    assign dl_rise   = ioctl_download & ~dl_q;
    assign load_busy = ioctl_download | buf_full;

    // RAM port values are computed here and registered on entry to the state that uses them.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        ram_we_d   = 1'b0;
        cpu_rd_d   = cpu_rd_q;
        buf_pop    = 1'b0;
        slot_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d    = CPU_ADDR;
                    ram_addr_d = cpu_addr;
                    ram_din_d  = cpu_din;
                    ram_we_d   = cpu_we;
                    cpu_rd_d   = ~cpu_we;
                end else if (buf_full) begin
                    state_d    = LD_WRITE;
                    ram_addr_d = buf_addr;
                    ram_din_d  = buf_data;
                    ram_we_d   = 1'b1;
                end
            end
            CPU_ADDR: state_d = CPU_DATA;
            CPU_DATA: begin
                if (buf_full) begin
                    state_d    = LD_WRITE;
                    ram_addr_d = buf_addr;
                    ram_din_d  = buf_data;
                    ram_we_d   = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            LD_WRITE: begin
                state_d = IDLE;
                buf_pop = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (cpu_req && state_q != IDLE) slot_err = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            cpu_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            ram_we   <= ram_we_d;
            cpu_rd_q <= cpu_rd_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_dout <= 8'hFF;
        end else if (state_q == CPU_DATA && cpu_rd_q) begin
            cpu_dout <= ram_dout;
        end
    end

    // A new download clears the stats; an error in that same cycle still registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            load_count <= '0;
            load_err   <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                load_count <= '0;
                load_err   <= buf_err | slot_err;
            end else begin
                if (buf_pop && load_count != '1)
                    load_count <= load_count + {{AW{1'b0}}, 1'b1};
                if (buf_err || slot_err)
                    load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_ram_arbiter.sv
// Self-checking bench for ioctl_ram_arbiter: directed scenarios plus a randomized mix
// of CPU slot traffic and loader writes checked against an address->data reference map.
module tb_ioctl_ram_arbiter;

    localparam int unsigned AW   = 16;
    localparam logic [7:0]  LIDX = 8'd0;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          cpu_slot, cpu_cs, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          ioctl_download, ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout, ioctl_index;
    logic          ioctl_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din, ram_dout;
    logic          load_busy;
    logic [AW:0]   load_count;
    logic          load_err;

    logic [7:0] ram_mem [0:65535];
    logic [7:0] exp_mem [int];
    int n_cmp = 0;
    int n_fail = 0;
    int exp_count = 0;

    always #5 clk_sys = ~clk_sys;

    ioctl_ram_arbiter #(
        .AW         (AW),
        .LOAD_INDEX (LIDX)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .cpu_slot       (cpu_slot),
        .cpu_cs         (cpu_cs),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .load_busy      (load_busy),
        .load_count     (load_count),
        .load_err       (load_err)
    );

    // Synchronous single-port RAM, one cycle read latency
    always @(posedge clk_sys) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_slot = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_index = LIDX;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        n_cmp++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL reset_cpu_dout got %h want ff", cpu_dout); end
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        n_cmp++; if (ram_addr !== '0 || ram_din !== '0) begin n_fail++; $display("FAIL reset_ram_bus got %h/%h want 0/0", ram_addr, ram_din); end
        n_cmp++; if (ioctl_wait !== 1'b0 || load_busy !== 1'b0) begin n_fail++; $display("FAIL reset_wait_busy got %b/%b want 0/0", ioctl_wait, load_busy); end
        n_cmp++; if (load_count !== '0 || load_err !== 1'b0) begin n_fail++; $display("FAIL reset_stats got %0d/%b want 0/0", load_count, load_err); end
    endtask

    task automatic test_cpu_read();
        cpu_slot = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_din = 8'hA5;
        step();
        cpu_slot = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'h1234 || ram_din !== 8'hA5) begin n_fail++; $display("FAIL cpu_wr_bus got we=%b a=%h d=%h want 1/1234/a5", ram_we, ram_addr, ram_din); end
        step();
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_one_cycle got %b want 0", ram_we); end
        step();
        n_cmp++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL cpu_wr_keeps_dout got %h want ff", cpu_dout); end
        exp_mem[32'h1234] = 8'hA5;
        repeat (5) step();
        cpu_slot = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        step();
        cpu_slot = 1'b0; cpu_cs = 1'b0;
        n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 16'h1234) begin n_fail++; $display("FAIL cpu_rd_addr got we=%b a=%h want 0/1234", ram_we, ram_addr); end
        step();
        n_cmp++; if (ram_we !== 1'b0 || cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL cpu_rd_early got we=%b d=%h want 0/ff", ram_we, cpu_dout); end
        step();
        n_cmp++; if (cpu_dout !== 8'hA5) begin n_fail++; $display("FAIL cpu_rd_n3 got %h want a5", cpu_dout); end
        repeat (5) step();
        n_cmp++; if (cpu_dout !== 8'hA5) begin n_fail++; $display("FAIL cpu_rd_hold got %h want a5", cpu_dout); end
    endtask

    task automatic test_loader_stream();
        int t;
        logic [7:0] d;
        ioctl_download = 1'b0; step();
        ioctl_download = 1'b1; ioctl_index = LIDX; step();
        exp_count = 0;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (ioctl_wait && t < 20) begin step(); t++; end
            n_cmp++; if (t >= 20) begin n_fail++; $display("FAIL stream_wait_timeout got wait=%b want 0", ioctl_wait); end
            d = 8'(17 * (i + 1));
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = d;
            step();
            ioctl_wr = 1'b0;
            exp_mem[i] = d;
            exp_count++;
        end
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ram_mem[i] !== exp_mem[i]) begin n_fail++; $display("FAIL stream_ram[%0d] got %h want %h", i, ram_mem[i], exp_mem[i]); end
        end
        n_cmp++; if (load_count !== (AW+1)'(exp_count) || load_err !== 1'b0) begin n_fail++; $display("FAIL stream_stats got %0d/%b want %0d/0", load_count, load_err, exp_count); end
        n_cmp++; if (ioctl_wait !== 1'b0 || load_busy !== 1'b1) begin n_fail++; $display("FAIL stream_idle got wait=%b busy=%b want 0/1", ioctl_wait, load_busy); end
    endtask

    task automatic test_collision();
        repeat (8) step();
        ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h77;
        step();
        ioctl_wr = 1'b0;
        cpu_slot = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd5; cpu_din = 8'h99;
        step();
        cpu_slot = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'd5 || ram_din !== 8'h99) begin n_fail++; $display("FAIL coll_cpu_n1 got we=%b a=%h d=%h want 1/0005/99", ram_we, ram_addr, ram_din); end
        step();
        n_cmp++; if (ram_we !== 1'b0 || ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL coll_n2 got we=%b wait=%b want 0/1", ram_we, ioctl_wait); end
        step();
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'd5 || ram_din !== 8'h77 || ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL coll_ld_n3 got we=%b a=%h d=%h wait=%b want 1/0005/77/1", ram_we, ram_addr, ram_din, ioctl_wait); end
        step();
        n_cmp++; if (ram_we !== 1'b0 || ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL coll_n4 got we=%b wait=%b want 0/0", ram_we, ioctl_wait); end
        exp_mem[5] = 8'h77;
        exp_count++;
        n_cmp++; if (ram_mem[5] !== 8'h77) begin n_fail++; $display("FAIL coll_ram5 got %h want 77", ram_mem[5]); end
        n_cmp++; if (load_count !== (AW+1)'(exp_count)) begin n_fail++; $display("FAIL coll_count got %0d want %0d", load_count, exp_count); end
    endtask

    task automatic test_overflow();
        int t;
        repeat (8) step();
        ioctl_wr = 1'b1; ioctl_addr = 25'd1; ioctl_dout = 8'h5A;
        step();
        n_cmp++; if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL ovf_wait_after_capture got %b want 1", ioctl_wait); end
        ioctl_addr = 25'd2; ioctl_dout = 8'h6B;
        step();
        ioctl_wr = 1'b0;
        exp_mem[1] = 8'h5A;
        exp_count++;
        n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", load_err); end
        t = 0;
        while (ioctl_wait && t < 20) begin step(); t++; end
        n_cmp++; if (t >= 20) begin n_fail++; $display("FAIL ovf_wait_timeout got wait=%b want 0", ioctl_wait); end
        ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'hC3;
        step();
        ioctl_wr = 1'b0;
        n_cmp++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL range_no_capture got wait=%b want 0", ioctl_wait); end
        repeat (4) step();
        n_cmp++; if (load_err !== 1'b1 || load_count !== (AW+1)'(exp_count)) begin n_fail++; $display("FAIL ovf_stats got %0d/%b want %0d/1", load_count, load_err, exp_count); end
        n_cmp++; if (ram_mem[0] !== 8'h11 || ram_mem[1] !== 8'h5A || ram_mem[2] !== 8'h33) begin n_fail++; $display("FAIL ovf_ram got %h %h %h want 11 5a 33", ram_mem[0], ram_mem[1], ram_mem[2]); end
    endtask

    task automatic test_download_clear();
        ioctl_download = 1'b0;
        step();
        n_cmp++; if (load_busy !== 1'b0 || load_err !== 1'b1 || load_count !== (AW+1)'(exp_count)) begin n_fail++; $display("FAIL dl_fall got busy=%b err=%b cnt=%0d want 0/1/%0d", load_busy, load_err, load_count, exp_count); end
        ioctl_download = 1'b1;
        step();
        exp_count = 0;
        n_cmp++; if (load_busy !== 1'b1 || load_err !== 1'b0 || load_count !== '0) begin n_fail++; $display("FAIL dl_rise got busy=%b err=%b cnt=%0d want 1/0/0", load_busy, load_err, load_count); end
    endtask

    task automatic test_random();
        int rd_due = -1;
        logic [7:0] rd_exp = '0;
        logic wait_chk = 1'b0;
        int a;
        logic [7:0] d;
        for (int c = 0; c < 800; c++) begin
            cpu_slot = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
            ioctl_wr = 1'b0; ioctl_index = LIDX;
            if (wait_chk) begin
                n_cmp++; if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL rnd_wait c=%0d got %b want 1", c, ioctl_wait); end
                wait_chk = 1'b0;
            end
            if (c == rd_due) begin
                n_cmp++; if (cpu_dout !== rd_exp) begin n_fail++; $display("FAIL rnd_cpu_rd c=%0d got %h want %h", c, cpu_dout, rd_exp); end
            end
            if (c % 8 == 0) begin
                cpu_slot = 1'b1;
                if ($urandom_range(0, 3) != 0) begin
                    a = 32'h8000 + int'($urandom_range(0, 15));
                    cpu_cs = 1'b1; cpu_addr = AW'(a);
                    if (!exp_mem.exists(a) || $urandom_range(0, 1) == 0) begin
                        d = 8'($urandom);
                        cpu_we = 1'b1; cpu_din = d;
                        exp_mem[a] = d;
                    end else begin
                        rd_due = c + 3; rd_exp = exp_mem[a];
                    end
                end
            end
            // Loader writes never land in a cycle whose LD_WRITE would meet the next slot
            if (c % 8 != 6 && !ioctl_wait && $urandom_range(0, 2) == 0) begin
                a = int'($urandom_range(16, 271));
                d = 8'($urandom);
                ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
                if ($urandom_range(0, 4) == 0) begin
                    ioctl_index = 8'd3;
                end else begin
                    exp_mem[a] = d;
                    exp_count++;
                    wait_chk = 1'b1;
                end
            end
            step();
        end
        cpu_slot = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; ioctl_wr = 1'b0; ioctl_index = LIDX;
        repeat (6) step();
        n_cmp++; if (load_count !== (AW+1)'(exp_count) || load_err !== 1'b0) begin n_fail++; $display("FAIL rnd_stats got %0d/%b want %0d/0", load_count, load_err, exp_count); end
        foreach (exp_mem[k]) begin
            n_cmp++; if (ram_mem[k] !== exp_mem[k]) begin n_fail++; $display("FAIL rnd_ram[%h] got %h want %h", k, ram_mem[k], exp_mem[k]); end
        end
    endtask

    task automatic test_reset_mid_load();
        repeat (8) step();
        cpu_slot = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        step();
        cpu_slot = 1'b0; cpu_cs = 1'b0;
        repeat (2) step();
        n_cmp++; if (cpu_dout !== 8'hA5) begin n_fail++; $display("FAIL rst_pre_read got %h want a5", cpu_dout); end
        repeat (6) step();
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'hEE;
        step();
        ioctl_wr = 1'b0;
        step();
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== '0) begin n_fail++; $display("FAIL rst_in_ld got we=%b a=%h want 1/0000", ram_we, ram_addr); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (ram_we !== 1'b0 || ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL rst_async got we=%b wait=%b want 0/0", ram_we, ioctl_wait); end
        n_cmp++; if (load_count !== '0 || load_err !== 1'b0 || cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL rst_values got cnt=%0d err=%b dout=%h want 0/0/ff", load_count, load_err, cpu_dout); end
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        n_cmp++; if (ram_mem[0] !== 8'h11 || ram_we !== 1'b0 || ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL rst_discard got ram0=%h we=%b wait=%b want 11/0/0", ram_mem[0], ram_we, ioctl_wait); end
        cpu_slot = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        step();
        cpu_slot = 1'b0; cpu_cs = 1'b0;
        repeat (2) step();
        n_cmp++; if (cpu_dout !== 8'hA5) begin n_fail++; $display("FAIL rst_first_slot got %h want a5", cpu_dout); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_loader_stream();
        test_collision();
        test_overflow();
        test_download_clear();
        test_random();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
